// File: rtl/shift_seq_unit_if.sv
// Operand/result bus between the control unit and the sequential shift unit.
// Handshake: start is a one-cycle request, taken only while the unit is idle (busy=0, done=0);
// done then pulses for exactly one cycle with Zlow valid. There is no backpressure.
interface shift_seq_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] Ra;
  logic [31:0] Rb;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [31:0] Zlow;

  modport master (output start, op, Ra, Rb, input busy, done, illegal, Zlow);
  modport slave  (input start, op, Ra, Rb, output busy, done, illegal, Zlow);
endinterface

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift/rotate unit: moves the operand at most STEP bit positions per clock
// and writes the final value to Zlow.
module shift_seq_unit #(
  parameter int STEP = 4
) (
  input  logic                 clock,
  input  logic                 clear_n,
  shift_seq_unit_if.slave      bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t      state;
  logic [2:0]  op_q;
  logic        illegal_q;
  logic [31:0] data;
  logic [4:0]  cnt;
  logic [31:0] zlow_q;

  logic [4:0]  s;
  logic [4:0]  cnt_next;
  logic [63:0] dd;
  logic [63:0] ror_w;
  logic [63:0] rol_w;
  logic [31:0] next_data;
  logic        unused_rb;

  assign unused_rb = ^bus.Rb[31:5];

  // Rotates are taken from the doubled word so a single shifter covers both directions.
  always_comb begin
    s         = (cnt < STEP5) ? cnt : STEP5;
    cnt_next  = cnt - s;
    dd        = {data, data};
    ror_w     = dd >> s;
    rol_w     = dd << s;
    next_data = data;
    case (op_q)
      3'd0:    next_data = data >> s;
      3'd1:    next_data = 32'($signed(data) >>> s);
      3'd2:    next_data = data << s;
      3'd3:    next_data = ror_w[31:0];
      3'd4:    next_data = rol_w[63:32];
      default: next_data = data;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      illegal_q <= 1'b0;
      data      <= 32'd0;
      cnt       <= 5'd0;
      zlow_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            illegal_q <= (bus.op > 3'd4);
            data      <= bus.Ra;
            cnt       <= bus.Rb[4:0];
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          data <= next_data;
          cnt  <= cnt_next;
          // Illegal ops finish on the first edge with the operand untouched.
          if (illegal_q || cnt_next == 5'd0) begin
            zlow_q <= next_data;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == SHIFT);
  assign bus.done    = (state == DONE);
  assign bus.illegal = (state == DONE) && illegal_q;
  assign bus.Zlow    = zlow_q;
  assign dbg_state   = state;

endmodule
